// File: rtl/psk_modulator.sv
// BPSK transmit modulator: phase accumulator + sine ROM with 180 degree flip per symbol.
// Define DIFF_ENC_EN for differential encoding (bit 1 = phase change at boundary).
module psk_modulator #(
  parameter int                     OUT_WIDTH   = 14,
  parameter int                     PHASE_WIDTH = 32,
  parameter logic [PHASE_WIDTH-1:0] FREQ_WORD   = PHASE_WIDTH'(32'h0200_0000),
  parameter int unsigned            SYM_CYCLES  = 32'd256,
  parameter int                     LUT_AW      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 sym_start,
  output logic                 busy,
  output logic                 underrun
);

  localparam int LUT_N = 2 ** LUT_AW;
  localparam int CNT_W = $clog2(SYM_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CYCLES - 1);
  localparam logic [OUT_WIDTH-1:0] MID = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam longint MIDL = 64'sd1 <<< (OUT_WIDTH - 1);
  localparam longint TWO_PI_Q = 64'sd6746518852;

  // Q30 Taylor series on a quarter wave, mirrored into the full table
  function automatic logic [OUT_WIDTH-1:0] rom_entry(input int k);
    longint x, x2, term, s, mag;
    int     q;
    logic   neg;
    neg = (k >= LUT_N / 2);
    q   = neg ? k - LUT_N / 2 : k;
    if (q > LUT_N / 4) q = LUT_N / 2 - q;
    x    = (longint'(q) * TWO_PI_Q) >>> LUT_AW;
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int n = 1; n < 10; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    mag = ((MIDL - 1) * s + (64'sd1 <<< 29)) >>> 30;
    rom_entry = neg ? OUT_WIDTH'(MIDL - mag) : OUT_WIDTH'(MIDL + mag);
  endfunction

  logic [OUT_WIDTH-1:0] rom [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_rom
    assign rom[g] = rom_entry(g);
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   buf_full_q, buf_full_d;
  logic                   buf_bit_q, buf_bit_d;
  logic                   cur_bit_q, cur_bit_d;
  logic [OUT_WIDTH-1:0]   dout_q, dout_d;
  logic                   sym_start_q, sym_start_d;
  logic                   busy_q, busy_d;
  logic                   underrun_q, underrun_d;

  logic              accept;
  logic              last;
  logic              load;
  logic              run;
  logic              next_flip;
  logic [LUT_AW-1:0] rom_addr;

  assign run      = enable && (state_q == RUN);
  assign last     = (cnt_q == CNT_LAST);
  assign accept   = bit_valid && !buf_full_q && enable;
  assign rom_addr = acc_q[PHASE_WIDTH-1 -: LUT_AW]
                  ^ {cur_bit_q, {(LUT_AW-1){1'b0}}};

`ifdef DIFF_ENC_EN
  assign next_flip = cur_bit_q ^ buf_bit_q;
`else
  assign next_flip = buf_bit_q;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    buf_full_d = buf_full_q;
    buf_bit_d  = buf_bit_q;
    cur_bit_d  = cur_bit_q;
    underrun_d = 1'b0;
    load       = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      acc_d      = '0;
      cnt_d      = '0;
      buf_full_d = 1'b0;
      cur_bit_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          acc_d     = '0;
          cnt_d     = '0;
          cur_bit_d = 1'b0;
          if (buf_full_q) begin
            state_d = RUN;
            load    = 1'b1;
          end
        end
        RUN: begin
          acc_d = acc_q + FREQ_WORD;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            cnt_d = '0;
            if (buf_full_q) begin
              load = 1'b1;
            end else begin
              state_d    = IDLE;
              acc_d      = '0;
              cur_bit_d  = 1'b0;
              underrun_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (load) begin
        cur_bit_d  = next_flip;
        buf_full_d = 1'b0;
      end
      if (accept) begin
        buf_full_d = 1'b1;
        buf_bit_d  = bit_in;
      end
    end
  end

  // Output flops trail acc/cur_bit by one clock so all outputs share the dout timing
  always_comb begin
    dout_d      = run ? rom[rom_addr] : MID;
    sym_start_d = run && (cnt_q == '0);
    busy_d      = run;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      buf_full_q  <= 1'b0;
      buf_bit_q   <= 1'b0;
      cur_bit_q   <= 1'b0;
      dout_q      <= MID;
      sym_start_q <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      buf_full_q  <= buf_full_d;
      buf_bit_q   <= buf_bit_d;
      cur_bit_q   <= cur_bit_d;
      dout_q      <= dout_d;
      sym_start_q <= sym_start_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bit_ready = ~buf_full_q;
  assign dout      = dout_q;
  assign sym_start = sym_start_q;
  assign busy      = busy_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_psk_modulator.sv
// Scoreboard bench for psk_modulator: symbol-level reference model plus directed checks.
module tb_psk_modulator;

  localparam int OW   = 14;
  localparam int SYM  = 256;
  localparam int MIDV = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic          sym_start;
  logic          busy;
  logic          underrun;
  logic [OW-1:0] dout;

  int vectors = 0;
  int miscompares = 0;

  psk_modulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .dout      (dout),
    .sym_start (sym_start),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] dout;
    logic          sym_start;
    logic          busy;
    logic          underrun;
    logic          ready;
  } exp_t;

  exp_t sb[$];

  bit m_run;
  int m_k;
  int m_p;
  bit m_flip;
  bit m_buf[$];

  // Carrier sample p of a run: LUT phase = p*FREQ_WORD/2^24, plus half a turn when flipped
  function automatic int sine_ref(int p, bit flip);
    longint a;
    real    v;
    a = ((longint'(p) * 64'h0200_0000) >> 24) + (flip ? 128 : 0);
    a = a % 256;
    v = 8191.0 * $sin(2.0 * 3.141592653589793 * real'(a) / 256.0);
    if (v >= 0.0) return MIDV + $rtoi($floor(v + 0.5));
    return MIDV - $rtoi($floor(-v + 0.5));
  endfunction

  function automatic bit flip_of(bit b);
`ifdef DIFF_ENC_EN
    return m_flip ^ b;
`else
    return b;
`endif
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   took;
    e = '{dout: OW'(MIDV), sym_start: 1'b0, busy: 1'b0,
          underrun: 1'b0, ready: 1'b1};
    if (!rst_n || !enable) begin
      m_run  = 0;
      m_flip = 0;
      m_k    = 0;
      m_p    = 0;
      m_buf.delete();
    end else begin
      took = bit_valid && (m_buf.size() == 0);
      if (m_run) begin
        e.dout      = OW'(sine_ref(m_p, m_flip));
        e.sym_start = (m_k == 0);
        e.busy      = 1'b1;
        e.underrun  = (m_k == SYM - 1) && (m_buf.size() == 0);
        m_p++;
        m_k++;
        if (m_k == SYM) begin
          m_k = 0;
          if (m_buf.size() != 0) begin
            m_flip = flip_of(m_buf.pop_front());
          end else begin
            m_run  = 0;
            m_flip = 0;
          end
        end
      end else if (m_buf.size() != 0) begin
        m_run  = 1;
        m_k    = 0;
        m_p    = 0;
        m_flip = flip_of(m_buf.pop_front());
      end
      if (took) m_buf.push_back(bit_in);
      e.ready = (m_buf.size() == 0);
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      exp_t a;
      e = sb.pop_front();
      a = {dout, sym_start, busy, underrun, bit_ready};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL sample t=%0t dout=%0d/%0d sym_start=%b/%b busy=%b/%b underrun=%b/%b ready=%b/%b (actual/required)",
                 $time, a.dout, e.dout, a.sym_start, e.sym_start, a.busy, e.busy,
                 a.underrun, e.underrun, a.ready, e.ready);
      end
    end
  end

  task automatic check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_sym(string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (sym_start === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: sym_start timeout, got none, required pulse", name);
    end
  endtask

  task automatic send_bit(bit b);
    int n = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    while (bit_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bit_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_bit: bit_ready timeout, got %b, required 1", bit_ready);
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int mode;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_dout", dout, 8192);
    check("idle_ready", bit_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_sym_start", sym_start, 0);

    send_bit(1'b0);
    wait_sym("t2_start", ok);
    if (ok) begin
      check("t2_s0", dout, 8192);
      check("t2_busy", busy, 1);
      repeat (32) @(negedge clk);
      check("t2_s32", dout, 16383);
      repeat (64) @(negedge clk);
      check("t2_s96", dout, 1);
      repeat (159) @(negedge clk);
      check("t2_underrun", underrun, 1);
      @(negedge clk);
      check("t2_after_dout", dout, 8192);
      check("t2_after_busy", busy, 0);
    end
    repeat (5) @(negedge clk);

    send_bit(1'b0);
    send_bit(1'b1);
    wait_sym("t3_start", ok);
    if (ok) begin
      repeat (256) @(negedge clk);
      check("t3_s256_start", sym_start, 1);
      check("t3_s256", dout, 8192);
      repeat (32) @(negedge clk);
      check("t3_s288", dout, 1);
    end
    repeat (300) @(negedge clk);

    send_bit(1'b0);
    wait_sym("t4_start", ok);
    if (ok) begin
      repeat (254) @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
      check("t4_underrun", underrun, 1);
      check("t4_ready", bit_ready, 0);
      @(negedge clk);
      check("t4_idle_dout", dout, 8192);
      check("t4_idle_busy", busy, 0);
      @(negedge clk);
      check("t4_restart", sym_start, 1);
      check("t4_restart_dout", dout, 8192);
    end
    repeat (300) @(negedge clk);

    send_bit(1'b0);
    send_bit(1'b1);
    wait_sym("t5_start", ok);
    if (ok) begin
      repeat (99) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("t5_dout", dout, 8192);
      check("t5_ready", bit_ready, 1);
      check("t5_underrun", underrun, 0);
      enable = 1'b1;
      repeat (20) @(negedge clk);
      check("t5_discard", busy, 0);
    end

`ifdef DIFF_ENC_EN
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (256) @(negedge clk);
    check("t6_start", sym_start, 1);
    check("t6_dout", dout, 8192);
    @(negedge clk);
    check("t6_rising", int'(dout > 14'd8192), 1);
    repeat (300) @(negedge clk);
`endif

    for (int seg = 0; seg < 12; seg++) begin
      mode = $urandom_range(0, 2);
      if (seg == 6) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      for (int c = 0; c < 1200; c++) begin
        @(negedge clk);
        bit_in = 1'($urandom_range(0, 1));
        case (mode)
          0: bit_valid = ($urandom_range(0, 3) != 0);
          1: bit_valid = ($urandom_range(0, 299) == 0);
          default: begin
            bit_valid = 1'($urandom_range(0, 1));
            enable    = ($urandom_range(0, 399) != 0);
          end
        endcase
      end
      enable = 1'b1;
    end
    bit_valid = 1'b0;
    repeat (600) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
